// File: rtl/serial_sequence_tx_pkg.sv
// Shared definitions for the serial sequence link: FSM state type and counter sizing.
package serial_sequence_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_e;

    // Bits needed to index 0..n-1, never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned bits;
        bits = 1;
        for (int unsigned v = 2; v < n; v = v * 2) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/serial_sequence_tx_shift_reg.sv
// Parallel-load, MSB-first shift register; the top reads the MSB as the next bit to send.
module serial_shift_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_sequence_tx.sv
// Serial bit-pattern transmitter: MSB-first frames with optional inter-frame gap.
// Optional trailing even-parity bit per frame when SERIAL_TX_PARITY_EN is defined.
module serial_sequence_tx
    import serial_sequence_tx_pkg::*;
#(
    parameter int unsigned PATTERN_WIDTH = 4,
    parameter int unsigned GAP_CYCLES    = 1,
    parameter int unsigned COUNT_WIDTH   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [PATTERN_WIDTH-1:0] load_pattern,
    input  logic [COUNT_WIDTH-1:0]   load_repeat,
    output logic                     w,
    output logic                     w_valid,
    output logic                     frame_start,
    output logic                     busy,
    output logic                     done
);

`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned FRAME_LEN = PATTERN_WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = PATTERN_WIDTH;
`endif
    localparam int unsigned IDX_W  = clog2(FRAME_LEN);
    localparam int unsigned GAP_W  = clog2((GAP_CYCLES > 0) ? GAP_CYCLES : 1);
    localparam int unsigned GAP_LD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    tx_state_e                state;
    logic [PATTERN_WIDTH-1:0] pat_q;
    logic [COUNT_WIDTH-1:0]   rep_q;
    logic [IDX_W-1:0]         bit_idx;
    logic [GAP_W-1:0]         gap_cnt;

    logic                     last_bit;
    logic                     more_frames;
    logic                     sr_load;
    logic                     sr_shift;
    logic [PATTERN_WIDTH-1:0] sr_src;
    logic [PATTERN_WIDTH-1:0] sr_load_data;
    logic                     sr_msb;

    assign last_bit    = (bit_idx == '0);
    assign more_frames = (rep_q != COUNT_WIDTH'(1));

    // The MSB goes straight to w at frame start, so the shifter holds the remaining bits.
    always_comb begin
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_src   = pat_q;
        case (state)
            IDLE: begin
                sr_load = load_valid;
                sr_src  = load_pattern;
            end
            SHIFT: begin
                sr_load  = last_bit && more_frames && (GAP_CYCLES == 0);
                sr_shift = !last_bit;
            end
            GAP: begin
                sr_load = (gap_cnt == '0);
            end
            default: ;
        endcase
        sr_load_data = {sr_src[PATTERN_WIDTH-2:0], 1'b0};
    end

    serial_shift_reg #(
        .WIDTH(PATTERN_WIDTH)
    ) u_shift (
        .clock    (clock),
        .reset    (reset),
        .load     (sr_load),
        .shift    (sr_shift),
        .load_data(sr_load_data),
        .msb      (sr_msb)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pat_q       <= '0;
            rep_q       <= '0;
            bit_idx     <= '0;
            gap_cnt     <= '0;
            w           <= 1'b0;
            w_valid     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            done        <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        pat_q       <= load_pattern;
                        rep_q       <= (load_repeat == '0) ? COUNT_WIDTH'(1) : load_repeat;
                        bit_idx     <= IDX_W'(FRAME_LEN - 1);
                        state       <= SHIFT;
                        w           <= load_pattern[PATTERN_WIDTH-1];
                        w_valid     <= 1'b1;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        load_ready  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        bit_idx <= bit_idx - IDX_W'(1);
`ifdef SERIAL_TX_PARITY_EN
                        w       <= (bit_idx == IDX_W'(1)) ? ^pat_q : sr_msb;
`else
                        w       <= sr_msb;
`endif
                    end else if (more_frames) begin
                        rep_q <= rep_q - COUNT_WIDTH'(1);
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_W'(GAP_LD);
                            w       <= 1'b0;
                            w_valid <= 1'b0;
                        end else begin
                            bit_idx     <= IDX_W'(FRAME_LEN - 1);
                            w           <= pat_q[PATTERN_WIDTH-1];
                            frame_start <= 1'b1;
                        end
                    end else begin
                        state      <= IDLE;
                        w          <= 1'b0;
                        w_valid    <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        load_ready <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state       <= SHIFT;
                        bit_idx     <= IDX_W'(FRAME_LEN - 1);
                        w           <= pat_q[PATTERN_WIDTH-1];
                        w_valid     <= 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sequence_tx.sv
// Bench for serial_sequence_tx: three gap configurations checked against a timeline model.
module tb_serial_sequence_tx;

    localparam int W = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam int GAPS [3] = '{1, 2, 0};
    localparam logic [5:0] IDLE_T = 6'b000001;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           load_valid = 1'b0;
    logic [W-1:0]   load_pattern = '0;
    logic [7:0]     load_repeat = '0;
    logic [2:0]     w_s, wv_s, fs_s, busy_s, done_s, lr_s;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit          act [3];
    int          tm  [3];
    logic [W-1:0] pm [3];
    int          rm  [3];
    logic [5:0]  exp_cur [3];

    always #5 clock = ~clock;

    serial_sequence_tx #(.PATTERN_WIDTH(W), .GAP_CYCLES(1), .COUNT_WIDTH(8)) dut_g1 (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(lr_s[0]),
        .load_pattern(load_pattern), .load_repeat(load_repeat), .w(w_s[0]),
        .w_valid(wv_s[0]), .frame_start(fs_s[0]), .busy(busy_s[0]), .done(done_s[0]));

    serial_sequence_tx #(.PATTERN_WIDTH(W), .GAP_CYCLES(2), .COUNT_WIDTH(8)) dut_g2 (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(lr_s[1]),
        .load_pattern(load_pattern), .load_repeat(load_repeat), .w(w_s[1]),
        .w_valid(wv_s[1]), .frame_start(fs_s[1]), .busy(busy_s[1]), .done(done_s[1]));

    serial_sequence_tx #(.PATTERN_WIDTH(W), .GAP_CYCLES(0), .COUNT_WIDTH(8)) dut_g0 (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(lr_s[2]),
        .load_pattern(load_pattern), .load_repeat(load_repeat), .w(w_s[2]),
        .w_valid(wv_s[2]), .frame_start(fs_s[2]), .busy(busy_s[2]), .done(done_s[2]));

    function automatic int total_of(input int rep, input int gap);
        int r;
        r = (rep == 0) ? 1 : rep;
        return r * FL + (r - 1) * gap;
    endfunction

    // Expected {w, w_valid, frame_start, busy, done, load_ready} t cycles after the first bit.
    function automatic logic [5:0] expect_at(input logic [W-1:0] pat, input int rep,
                                             input int gap, input int t);
        int p;
        logic b;
        if (t == total_of(rep, gap)) return 6'b000011;
        p = t % (FL + gap);
        if (p >= FL) return 6'b000100;
        b = (p < W) ? pat[W-1-p] : ^pat;
        return {b, 1'b1, (p == 0), 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic cycle();
        logic [5:0] obs;
        bit hs;
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            hs = load_valid && exp_cur[i][0];
            if (reset) begin
                act[i] = 1'b0;
            end else if (hs) begin
                act[i] = 1'b1;
                tm[i]  = 0;
                pm[i]  = load_pattern;
                rm[i]  = int'(load_repeat);
            end else if (act[i]) begin
                if (tm[i] < total_of(rm[i], GAPS[i])) tm[i] = tm[i] + 1;
                else act[i] = 1'b0;
            end
            exp_cur[i] = act[i] ? expect_at(pm[i], rm[i], GAPS[i], tm[i]) : IDLE_T;
        end
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            obs = {w_s[i], wv_s[i], fs_s[i], busy_s[i], done_s[i], lr_s[i]};
            checks++;
            assert (obs === exp_cur[i]) else begin
                errors++;
                $error("FAIL outputs dut%0d cyc%0d observed=%b expected=%b", i, cyc, obs, exp_cur[i]);
            end
        end
    endtask

    int nbusy [3];
    int nfs   [3];
    int ndone [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0; tm[i] = 0; pm[i] = '0; rm[i] = 0; exp_cur[i] = IDLE_T;
            nbusy[i] = 0; nfs[i] = 0; ndone[i] = 0;
        end

        // reset, then idle
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (10) cycle();

        // single 1101 frame; inputs scrambled after the handshake
        load_pattern = 4'b1101; load_repeat = 8'd1; load_valid = 1'b1;
        cycle();
        load_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            load_pattern = W'($urandom); load_repeat = 8'($urandom);
            cycle();
        end

        // three frames: count busy cycles, frame starts and done pulses
        load_pattern = 4'b1101; load_repeat = 8'd3; load_valid = 1'b1;
        for (int k = 0; k < 22; k++) begin
            cycle();
            load_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                nbusy[i] += int'(busy_s[i]); nfs[i] += int'(fs_s[i]); ndone[i] += int'(done_s[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            assert (nbusy[i] === total_of(3, GAPS[i])) else begin
                errors++;
                $error("FAIL busy_count dut%0d observed=%0d expected=%0d", i, nbusy[i], total_of(3, GAPS[i]));
            end
            checks++;
            assert (nfs[i] === 3) else begin
                errors++;
                $error("FAIL frame_starts dut%0d observed=%0d expected=3", i, nfs[i]);
            end
            checks++;
            assert (ndone[i] === 1) else begin
                errors++;
                $error("FAIL done_count dut%0d observed=%0d expected=1", i, ndone[i]);
            end
        end

        // reset during the second bit aborts the frame; load_valid while busy is ignored
        load_pattern = 4'b1101; load_repeat = 8'd2; load_valid = 1'b1;
        cycle();
        load_valid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (3) cycle();
        load_pattern = 4'b1001; load_repeat = 8'd1; load_valid = 1'b1;
        cycle();
        load_pattern = 4'b0110; load_repeat = 8'd5;
        repeat (3) cycle();
        load_valid = 1'b0;
        repeat (6) cycle();

        // load_valid held high: every done cycle re-handshakes
        load_pattern = 4'b1011; load_repeat = 8'd2; load_valid = 1'b1;
        repeat (30) cycle();
        load_valid = 1'b0;
        repeat (15) cycle();

        // randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            reset        = ($urandom_range(0, 99) == 0);
            load_valid   = ($urandom_range(0, 3) == 0);
            load_pattern = W'($urandom);
            load_repeat  = 8'($urandom_range(0, 3));
            cycle();
        end
        reset = 1'b0; load_valid = 1'b0;
        repeat (30) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
